// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the MIPS instruction encoder: operation IDs,
// opcode/function constants and instruction field bit ranges.
package instr_encoder_pkg;

  typedef enum logic [5:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR, OP_JALR,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ, OP_JAL, OP_J
  } op_e;

  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] OPCODE_REGIMM  = 6'h01;
  localparam logic [5:0] OPCODE_J       = 6'h02;
  localparam logic [5:0] OPCODE_JAL     = 6'h03;
  localparam logic [5:0] OPCODE_BEQ     = 6'h04;
  localparam logic [5:0] OPCODE_BNE     = 6'h05;
  localparam logic [5:0] OPCODE_BLEZ    = 6'h06;
  localparam logic [5:0] OPCODE_BGTZ    = 6'h07;
  localparam logic [5:0] OPCODE_ADDI    = 6'h08;
  localparam logic [5:0] OPCODE_ADDIU   = 6'h09;
  localparam logic [5:0] OPCODE_SLTI    = 6'h0a;
  localparam logic [5:0] OPCODE_SLTIU   = 6'h0b;
  localparam logic [5:0] OPCODE_ANDI    = 6'h0c;
  localparam logic [5:0] OPCODE_ORI     = 6'h0d;
  localparam logic [5:0] OPCODE_XORI    = 6'h0e;
  localparam logic [5:0] OPCODE_LUI     = 6'h0f;
  localparam logic [5:0] OPCODE_LB      = 6'h20;
  localparam logic [5:0] OPCODE_LH      = 6'h21;
  localparam logic [5:0] OPCODE_LW      = 6'h23;
  localparam logic [5:0] OPCODE_LBU     = 6'h24;
  localparam logic [5:0] OPCODE_LHU     = 6'h25;
  localparam logic [5:0] OPCODE_SB      = 6'h28;
  localparam logic [5:0] OPCODE_SH      = 6'h29;
  localparam logic [5:0] OPCODE_SW      = 6'h2b;

  localparam logic [5:0] FUNC_SLL   = 6'h00;
  localparam logic [5:0] FUNC_SRL   = 6'h02;
  localparam logic [5:0] FUNC_SRA   = 6'h03;
  localparam logic [5:0] FUNC_SLLV  = 6'h04;
  localparam logic [5:0] FUNC_SRLV  = 6'h06;
  localparam logic [5:0] FUNC_SRAV  = 6'h07;
  localparam logic [5:0] FUNC_JR    = 6'h08;
  localparam logic [5:0] FUNC_JALR  = 6'h09;
  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1a;
  localparam logic [5:0] FUNC_DIVU  = 6'h1b;
  localparam logic [5:0] FUNC_ADD   = 6'h20;
  localparam logic [5:0] FUNC_ADDU  = 6'h21;
  localparam logic [5:0] FUNC_SUB   = 6'h22;
  localparam logic [5:0] FUNC_SUBU  = 6'h23;
  localparam logic [5:0] FUNC_AND   = 6'h24;
  localparam logic [5:0] FUNC_OR    = 6'h25;
  localparam logic [5:0] FUNC_XOR   = 6'h26;
  localparam logic [5:0] FUNC_NOR   = 6'h27;
  localparam logic [5:0] FUNC_SLT   = 6'h2a;
  localparam logic [5:0] FUNC_SLTU  = 6'h2b;

  localparam logic [4:0] REGIMM_BLTZ = 5'b00000;
  localparam logic [4:0] REGIMM_BGEZ = 5'b00001;

  localparam int unsigned OPCODE_MSB = 31, OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25, RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20, RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15, RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10, SHAMT_LSB  = 6;
  localparam int unsigned FUNC_MSB   = 5,  FUNC_LSB   = 0;
  localparam int unsigned IMM_MSB    = 15, IMM_LSB    = 0;
  localparam int unsigned TARGET_MSB = 25, TARGET_LSB = 0;

  // Multiply/divide unit operations, which can be compiled out.
  function automatic logic is_mdu(input logic [5:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Circular-buffer FIFO for encoded words. The head output holds the last
// popped word while empty so the consumer never sees a stale slot.
module instr_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = empty ? last_q : mem_q[rd_ptr_q];

  // Next pointers, occupancy, storage write and held-head value.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage needs no reset because occupancy gates it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: op_id + fields -> canonical 32-bit word, queued
// through instr_fifo. Macro MDU_OPS_EN enables the multiply/divide ops.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op_id,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [4:0]       shamt,
  input  logic [15:0]      imm,
  input  logic [25:0]      target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] enc_count
);

  logic [31:0]      word;
  logic             known, legal, mdu_ok, accept, push, full, empty;
  logic             is_r, is_j;
  logic [5:0]       opc, func;
  logic [4:0]       f_rs, f_rt, f_rd, f_sh;
  logic             err_q, err_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;

`ifdef MDU_OPS_EN
  assign mdu_ok = 1'b1;
`else
  assign mdu_ok = 1'b0;
`endif

  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign out_valid = !empty;
  assign err       = err_q;
  assign enc_count = enc_count_q;

  // Encode mux: pick format, opcode/func, and zero fields the op ignores.
  always_comb begin
    known = 1'b1;
    is_r  = 1'b1;
    is_j  = 1'b0;
    opc   = OPCODE_SPECIAL;
    func  = '0;
    f_rs  = rs;
    f_rt  = rt;
    f_rd  = rd;
    f_sh  = shamt;
    case (op_id)
      OP_ADD:   begin func = FUNC_ADD;  f_sh = '0; end
      OP_ADDU:  begin func = FUNC_ADDU; f_sh = '0; end
      OP_SUB:   begin func = FUNC_SUB;  f_sh = '0; end
      OP_SUBU:  begin func = FUNC_SUBU; f_sh = '0; end
      OP_AND:   begin func = FUNC_AND;  f_sh = '0; end
      OP_OR:    begin func = FUNC_OR;   f_sh = '0; end
      OP_XOR:   begin func = FUNC_XOR;  f_sh = '0; end
      OP_NOR:   begin func = FUNC_NOR;  f_sh = '0; end
      OP_SLT:   begin func = FUNC_SLT;  f_sh = '0; end
      OP_SLTU:  begin func = FUNC_SLTU; f_sh = '0; end
      OP_SLL:   begin func = FUNC_SLL;  f_rs = '0; end
      OP_SRL:   begin func = FUNC_SRL;  f_rs = '0; end
      OP_SRA:   begin func = FUNC_SRA;  f_rs = '0; end
      OP_SLLV:  begin func = FUNC_SLLV; f_sh = '0; end
      OP_SRLV:  begin func = FUNC_SRLV; f_sh = '0; end
      OP_SRAV:  begin func = FUNC_SRAV; f_sh = '0; end
      OP_JR:    begin func = FUNC_JR;   f_rt = '0; f_rd = '0; f_sh = '0; end
      OP_JALR:  begin func = FUNC_JALR; f_rt = '0; f_sh = '0; end
      OP_MULT:  begin func = FUNC_MULT;  f_rd = '0; f_sh = '0; end
      OP_MULTU: begin func = FUNC_MULTU; f_rd = '0; f_sh = '0; end
      OP_DIV:   begin func = FUNC_DIV;   f_rd = '0; f_sh = '0; end
      OP_DIVU:  begin func = FUNC_DIVU;  f_rd = '0; f_sh = '0; end
      OP_MFHI:  begin func = FUNC_MFHI;  f_rs = '0; f_rt = '0; f_sh = '0; end
      OP_MFLO:  begin func = FUNC_MFLO;  f_rs = '0; f_rt = '0; f_sh = '0; end
      OP_MTHI:  begin func = FUNC_MTHI;  f_rt = '0; f_rd = '0; f_sh = '0; end
      OP_MTLO:  begin func = FUNC_MTLO;  f_rt = '0; f_rd = '0; f_sh = '0; end
      OP_ADDI:  begin is_r = 1'b0; opc = OPCODE_ADDI;  end
      OP_ADDIU: begin is_r = 1'b0; opc = OPCODE_ADDIU; end
      OP_SLTI:  begin is_r = 1'b0; opc = OPCODE_SLTI;  end
      OP_SLTIU: begin is_r = 1'b0; opc = OPCODE_SLTIU; end
      OP_ANDI:  begin is_r = 1'b0; opc = OPCODE_ANDI;  end
      OP_ORI:   begin is_r = 1'b0; opc = OPCODE_ORI;   end
      OP_XORI:  begin is_r = 1'b0; opc = OPCODE_XORI;  end
      OP_LUI:   begin is_r = 1'b0; opc = OPCODE_LUI;  f_rs = '0; end
      OP_LB:    begin is_r = 1'b0; opc = OPCODE_LB;    end
      OP_LH:    begin is_r = 1'b0; opc = OPCODE_LH;    end
      OP_LW:    begin is_r = 1'b0; opc = OPCODE_LW;    end
      OP_LBU:   begin is_r = 1'b0; opc = OPCODE_LBU;   end
      OP_LHU:   begin is_r = 1'b0; opc = OPCODE_LHU;   end
      OP_SB:    begin is_r = 1'b0; opc = OPCODE_SB;    end
      OP_SH:    begin is_r = 1'b0; opc = OPCODE_SH;    end
      OP_SW:    begin is_r = 1'b0; opc = OPCODE_SW;    end
      OP_BEQ:   begin is_r = 1'b0; opc = OPCODE_BEQ;   end
      OP_BNE:   begin is_r = 1'b0; opc = OPCODE_BNE;   end
      OP_BLEZ:  begin is_r = 1'b0; opc = OPCODE_BLEZ; f_rt = '0; end
      OP_BGTZ:  begin is_r = 1'b0; opc = OPCODE_BGTZ; f_rt = '0; end
      OP_BLTZ:  begin is_r = 1'b0; opc = OPCODE_REGIMM; f_rt = REGIMM_BLTZ; end
      OP_BGEZ:  begin is_r = 1'b0; opc = OPCODE_REGIMM; f_rt = REGIMM_BGEZ; end
      OP_JAL:   begin is_r = 1'b0; is_j = 1'b1; opc = OPCODE_JAL; end
      OP_J:     begin is_r = 1'b0; is_j = 1'b1; opc = OPCODE_J;   end
      default:  known = 1'b0;
    endcase
    legal = known && (mdu_ok || !is_mdu(op_id));
  end

  // Assemble the word from the selected format and fields.
  always_comb begin
    word = '0;
    word[OPCODE_MSB:OPCODE_LSB] = opc;
    if (is_j) begin
      word[TARGET_MSB:TARGET_LSB] = target;
    end else begin
      word[RS_MSB:RS_LSB] = f_rs;
      word[RT_MSB:RT_LSB] = f_rt;
      if (is_r) begin
        word[RD_MSB:RD_LSB]       = f_rd;
        word[SHAMT_MSB:SHAMT_LSB] = f_sh;
        word[FUNC_MSB:FUNC_LSB]   = func;
      end else begin
        word[IMM_MSB:IMM_LSB] = imm;
      end
    end
  end

  // Error pulse and encoded-word counter next state.
  always_comb begin
    err_d       = accept && !legal;
    enc_count_d = enc_count_q + (push ? CNT_W'(1) : CNT_W'(0));
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q       <= 1'b0;
      enc_count_q <= '0;
    end else begin
      err_q       <= err_d;
      enc_count_q <= enc_count_d;
    end
  end

  instr_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (word),
    .pop       (out_ready),
    .full      (full),
    .empty     (empty),
    .head      (instr)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (honours MDU_OPS_EN).
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, err;
  logic [5:0]  op_id;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] instr;
  logic [15:0] enc_count;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_id(op_id), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .target(target), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr), .err(err), .enc_count(enc_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
                       input logic [25:0] tg);
    op_id = o; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_err", err, 0);
    check("rst_cnt", enc_count, 0);
    reset = 1'b0;
    step();

    // addu: shamt forced to zero, visible one cycle after accept
    drive(OP_ADDU, 5'd1, 5'd2, 5'd3, 5'd5, 16'd0, 26'd0);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    exp_cnt = 1;
    check("addu_valid", out_valid, 1);
    check("addu_word", instr, 32'h00221821);
    check("addu_cnt", enc_count, exp_cnt);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("addu_popped", out_valid, 0);
    check("empty_hold", instr, 32'h00221821);

    // four back-to-back words, drained in order
    in_valid = 1'b1;
    drive(OP_ORI, 5'd0, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0); step();
    drive(OP_BGEZ, 5'd4, 5'd0, 5'd0, 5'd0, 16'hFFFE, 26'd0); step();
    drive(OP_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0100000); step();
    drive(OP_SLL, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0); step();
    in_valid = 1'b0;
    exp_cnt = 5;
    check("seq_cnt", enc_count, exp_cnt);
    check("seq_ori", instr, 32'h34011234);
    out_ready = 1'b1; step();
    check("seq_bgez", instr, 32'h0481FFFE);
    step();
    check("seq_j", instr, 32'h08100000);
    step();
    check("seq_nop_valid", out_valid, 1);
    check("seq_nop", instr, 32'h00000000);
    step();
    check("seq_empty", out_valid, 0);
    out_ready = 1'b0;

    // fill: 4 accepted, fifth held back until space frees
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(OP_ADDI, 5'd0, 5'(i), 5'd0, 5'd0, 16'(i), 26'd0);
      if (i < 5) step();
    end
    exp_cnt = 9;
    check("full_ready", in_ready, 0);
    check("full_cnt", enc_count, exp_cnt);
    check("full_head", instr, 32'h20010001);
    step();
    check("full_stall_ready", in_ready, 0);
    check("full_stall_cnt", enc_count, exp_cnt);
    check("full_stable_valid", out_valid, 1);
    check("full_stable_head", instr, 32'h20010001);
    out_ready = 1'b1; step();
    check("drain_w2", instr, 32'h20020002);
    check("drain_cnt_a", enc_count, exp_cnt);
    check("drain_ready", in_ready, 1);
    step(); in_valid = 1'b0;
    exp_cnt = 10;
    check("drain_w3", instr, 32'h20030003);
    check("drain_cnt_b", enc_count, exp_cnt);
    step();
    check("drain_w4", instr, 32'h20040004);
    step();
    check("drain_w5", instr, 32'h20050005);
    step();
    check("drain_empty", out_valid, 0);
    out_ready = 1'b0;

    // mult: encoded or rejected depending on build
    drive(OP_MULT, 5'd4, 5'd5, 5'd9, 5'd3, 16'd0, 26'd0);
    in_valid = 1'b1; step(); in_valid = 1'b0;
`ifdef MDU_OPS_EN
    exp_cnt = 11;
    check("mult_valid", out_valid, 1);
    check("mult_word", instr, 32'h00850018);
    check("mult_err", err, 0);
    check("mult_cnt", enc_count, exp_cnt);
    out_ready = 1'b1; step(); out_ready = 1'b0;
`else
    check("mult_err", err, 1);
    check("mult_valid", out_valid, 0);
    check("mult_cnt", enc_count, exp_cnt);
    step();
    check("mult_err_pulse", err, 0);
`endif

    // op_id past the end of the enum
    drive(6'd50, 5'd1, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
    check("ill_ready", in_ready, 1);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    check("ill_err", err, 1);
    check("ill_valid", out_valid, 0);
    check("ill_cnt", enc_count, exp_cnt);
    step();
    check("ill_err_pulse", err, 0);

    // reset mid-stream with three words pending and an illegal request
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(OP_LW, 5'd29, 5'd8, 5'd0, 5'd0, 16'(4 * i), 26'd0);
      step();
    end
    drive(6'd63, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    reset = 1'b1; step();
    check("mrst_valid", out_valid, 0);
    check("mrst_ready", in_ready, 1);
    check("mrst_cnt", enc_count, 0);
    check("mrst_instr", instr, 0);
    check("mrst_err", err, 0);
    reset = 1'b0; in_valid = 1'b0; step();
    check("mrst_valid_after", out_valid, 0);
    check("mrst_err_after", err, 0);

    // field forcing after reset: no stale word may precede these
    in_valid = 1'b1;
    drive(OP_SLL, 5'd7, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0); step();
    drive(OP_LUI, 5'd3, 5'd4, 5'd0, 5'd0, 16'hABCD, 26'd0); step();
    drive(OP_JR, 5'd31, 5'd5, 5'd6, 5'd7, 16'd0, 26'd0); step();
    in_valid = 1'b0;
    check("post_cnt", enc_count, 3);
    check("post_sll", instr, 32'h00021900);
    out_ready = 1'b1; step();
    check("post_lui", instr, 32'h3C04ABCD);
    step();
    check("post_jr", instr, 32'h03E00008);
    step();
    check("post_empty", out_valid, 0);
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
